// File: rtl/reg_wb_pkg.sv
// Shared types for the register writeback path: widths, write_en encodings
// and the buffered result entry.
package reg_wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_P0   = 2'b01;
  localparam logic [1:0] WE_BOTH = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Producer handshakes, dual register-file write port and hazard lookup of the writeback unit.
// master = surrounding pipeline side, slave = writeback unit side.
interface reg_writeback_unit_if;
  import reg_wb_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic [1:0]        write_en;
  logic [ADDR_W-1:0] reg_write_addr_0;
  logic [DATA_W-1:0] data_in_0;
  logic [ADDR_W-1:0] reg_write_addr_1;
  logic [DATA_W-1:0] data_in_1;
  logic [ADDR_W-1:0] query_addr_0;
  logic [ADDR_W-1:0] query_addr_1;
  logic              pending_0;
  logic              pending_1;
  logic              idle;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           query_addr_0, query_addr_1,
    input  alu_ready, mem_ready, write_en, reg_write_addr_0, data_in_0,
           reg_write_addr_1, data_in_1, pending_0, pending_1, idle
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           query_addr_0, query_addr_1,
    output alu_ready, mem_ready, write_en, reg_write_addr_0, data_in_0,
           reg_write_addr_1, data_in_1, pending_0, pending_1, idle
  );

endinterface

// File: rtl/reg_wb_fifo.sv
// In-order circular buffer, 2 pushes + up to 2 pops per cycle; head visible the cycle after push.
// No internal backpressure: caller must never push past DEPTH or pop more than count.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_a,
  input  wb_entry_t                      push_a_dat,
  input  logic                           push_b,
  input  wb_entry_t                      push_b_dat,
  input  logic [1:0]                     pop_cnt,
  output wb_entry_t                      head,
  output wb_entry_t                      head_next,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output wb_entry_t [DEPTH-1:0]          entries,
  output logic [DEPTH-1:0]               entry_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_b;
  logic [PTR_W-1:0]      rd_ptr_nxt;

  // push_b lands behind push_a when both arrive together
  assign wr_ptr_b   = wr_ptr + PTR_W'(push_a);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= push_a_dat;
    if (push_b) mem[wr_ptr_b] <= push_b_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
      count  <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop_cnt);
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr_nxt];
  assign entries   = mem;

  always_comb begin
    entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] off;
      off          = PTR_W'(i) - rd_ptr;
      entry_vld[i] = CNT_W'(off) < count;
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Buffers ALU/load results and drains up to two per cycle to the register file; accept->present 1 cycle.
// Both producers are stalled together once fewer than two FIFO slots remain, or during reset.
module reg_writeback_unit
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  reg_writeback_unit_if.slave wb
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  wb_entry_t             head;
  wb_entry_t             head_next;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      entry_vld;
  logic [CNT_W-1:0]      count;
  logic                  ready;
  logic                  alu_acc;
  logic                  mem_acc;
  logic [1:0]            pop_cnt;

  logic [1:0]            write_en;
  logic [ADDR_W-1:0]     addr_0;
  logic [DATA_W-1:0]     data_0;
  logic [ADDR_W-1:0]     addr_1;
  logic [DATA_W-1:0]     data_1;

  assign ready   = (count <= READY_MAX) && !rst;
  assign alu_acc = wb.alu_valid && ready;
  assign mem_acc = wb.mem_valid && ready;

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (alu_acc),
    .push_a_dat ('{addr: wb.alu_addr, data: wb.alu_data}),
    .push_b     (mem_acc),
    .push_b_dat ('{addr: wb.mem_addr, data: wb.mem_data}),
    .pop_cnt    (pop_cnt),
    .head       (head),
    .head_next  (head_next),
    .count      (count),
    .entries    (entries),
    .entry_vld  (entry_vld)
  );

  // Two writes to one register in the same cycle would lose program order
  always_comb begin
    pop_cnt = 2'd0;
    if (count == CNT_W'(1))
      pop_cnt = 2'd1;
    else if (count >= CNT_W'(2))
      pop_cnt = (head.addr != head_next.addr) ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en <= WE_NONE;
      addr_0   <= '0;
      data_0   <= '0;
      addr_1   <= '0;
      data_1   <= '0;
    end else begin
      case (pop_cnt)
        2'd1: begin
          write_en <= WE_P0;
          addr_0   <= head.addr;
          data_0   <= head.data;
        end
        2'd2: begin
          write_en <= WE_BOTH;
          addr_0   <= head.addr;
          data_0   <= head.data;
          addr_1   <= head_next.addr;
          data_1   <= head_next.data;
        end
        default: write_en <= WE_NONE;
      endcase
    end
  end

  always_comb begin
    wb.pending_0 = (write_en[0] && addr_0 == wb.query_addr_0) ||
                   (write_en[1] && addr_1 == wb.query_addr_0);
    wb.pending_1 = (write_en[0] && addr_0 == wb.query_addr_1) ||
                   (write_en[1] && addr_1 == wb.query_addr_1);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && entries[i].addr == wb.query_addr_0) wb.pending_0 = 1'b1;
      if (entry_vld[i] && entries[i].addr == wb.query_addr_1) wb.pending_1 = 1'b1;
    end
  end

  assign wb.alu_ready        = ready;
  assign wb.mem_ready        = ready;
  assign wb.write_en         = write_en;
  assign wb.reg_write_addr_0 = addr_0;
  assign wb.data_in_0        = data_0;
  assign wb.reg_write_addr_1 = addr_1;
  assign wb.data_in_1        = data_1;
  assign wb.idle             = (count == '0) && (write_en == WE_NONE);

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit: vector table plus throughput and reset sequences.
// Models the register file to confirm committed values.
module tb_reg_writeback_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  reg_writeback_unit_if wb_bus ();

  reg_writeback_unit #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: commits whatever is presented at each edge
  logic [15:0] rf [8] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (wb_bus.write_en[0]) rf[wb_bus.reg_write_addr_0] <= wb_bus.data_in_0;
    if (wb_bus.write_en[1]) rf[wb_bus.reg_write_addr_1] <= wb_bus.data_in_1;
  end

  typedef struct {
    logic        av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [2:0]  ma;
    logic [15:0] md;
    logic [2:0]  q0;
    logic [2:0]  q1;
    logic        e_rdy;
    logic [1:0]  e_we;
    logic        chk_p0;
    logic [2:0]  e_a0;
    logic [15:0] e_d0;
    logic [2:0]  e_a1;
    logic [15:0] e_d1;
    logic        e_p0;
    logic        e_p1;
    logic        e_idle;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [15:0] md,
                       input logic [2:0] q0, input logic [2:0] q1);
    wb_bus.alu_valid    = av;
    wb_bus.alu_addr     = aa;
    wb_bus.alu_data     = ad;
    wb_bus.mem_valid    = mv;
    wb_bus.mem_addr     = ma;
    wb_bus.mem_data     = md;
    wb_bus.query_addr_0 = q0;
    wb_bus.query_addr_1 = q1;
  endtask

  function automatic vec_t mk(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                              input logic mv, input logic [2:0] ma, input logic [15:0] md,
                              input logic [2:0] q0, input logic [2:0] q1,
                              input logic [1:0] e_we, input logic chk_p0,
                              input logic [2:0] e_a0, input logic [15:0] e_d0,
                              input logic [2:0] e_a1, input logic [15:0] e_d1,
                              input logic e_p0, input logic e_p1, input logic e_idle);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
    v.q0 = q0; v.q1 = q1; v.e_rdy = 1'b1; v.e_we = e_we; v.chk_p0 = chk_p0;
    v.e_a0 = e_a0; v.e_d0 = e_d0; v.e_a1 = e_a1; v.e_d1 = e_d1;
    v.e_p0 = e_p0; v.e_p1 = e_p1; v.e_idle = e_idle;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //             av aa  ad        mv ma  md        q0 q1  we     c0 a0  d0        a1  d1        p0 p1 idle
    vecs[0]  = mk(1, 2, 16'h1234, 0, 0, 16'h0000, 2, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 2, 1, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 2, 1, 2'b01, 1, 2, 16'h1234, 0, 16'h0000, 1, 0, 0);
    vecs[3]  = mk(1, 5, 16'h5678, 1, 3, 16'h1010, 5, 3, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[4]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 5, 3, 2'b00, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 5, 3, 2'b11, 1, 5, 16'h5678, 3, 16'h1010, 1, 1, 0);
    vecs[6]  = mk(1, 2, 16'h2345, 1, 2, 16'h9999, 2, 3, 2'b00, 0, 0, 16'h0000, 3, 16'h1010, 0, 0, 1);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 2'b00, 0, 0, 16'h0000, 3, 16'h1010, 1, 0, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 2'b01, 1, 2, 16'h2345, 3, 16'h1010, 1, 0, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 2'b01, 1, 2, 16'h9999, 3, 16'h1010, 1, 0, 0);
    vecs[10] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 2, 3, 2'b00, 0, 0, 16'h0000, 3, 16'h1010, 0, 0, 1);
    vecs[11] = mk(1, 6, 16'h00AA, 0, 0, 16'h0000, 6, 1, 2'b00, 0, 0, 16'h0000, 3, 16'h1010, 0, 0, 1);
    vecs[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 6, 1, 2'b00, 0, 0, 16'h0000, 3, 16'h1010, 1, 0, 0);
    vecs[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 6, 1, 2'b01, 1, 6, 16'h00AA, 3, 16'h1010, 1, 0, 0);
    vecs[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 6, 1, 2'b00, 0, 0, 16'h0000, 3, 16'h1010, 0, 0, 1);

    rst = 1'b1;
    drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, wb_bus.alu_ready}, 32'd0);
    check("rst_we", {30'd0, wb_bus.write_en}, 32'd0);
    check("rst_d0", {16'd0, wb_bus.data_in_0}, 32'd0);
    check("rst_idle", {31'd0, wb_bus.idle}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md,
            vecs[i].q0, vecs[i].q1);
      #1;
      check($sformatf("v%0d_alu_ready", i), {31'd0, wb_bus.alu_ready}, {31'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_mem_ready", i), {31'd0, wb_bus.mem_ready}, {31'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_we", i), {30'd0, wb_bus.write_en}, {30'd0, vecs[i].e_we});
      if (vecs[i].chk_p0) begin
        check($sformatf("v%0d_a0", i), {29'd0, wb_bus.reg_write_addr_0}, {29'd0, vecs[i].e_a0});
        check($sformatf("v%0d_d0", i), {16'd0, wb_bus.data_in_0}, {16'd0, vecs[i].e_d0});
      end
      check($sformatf("v%0d_a1", i), {29'd0, wb_bus.reg_write_addr_1}, {29'd0, vecs[i].e_a1});
      check($sformatf("v%0d_d1", i), {16'd0, wb_bus.data_in_1}, {16'd0, vecs[i].e_d1});
      check($sformatf("v%0d_pend0", i), {31'd0, wb_bus.pending_0}, {31'd0, vecs[i].e_p0});
      check($sformatf("v%0d_pend1", i), {31'd0, wb_bus.pending_1}, {31'd0, vecs[i].e_p1});
      check($sformatf("v%0d_idle", i), {31'd0, wb_bus.idle}, {31'd0, vecs[i].e_idle});
      @(negedge clk);
    end
    check("rf2_after_same_addr", {16'd0, rf[2]}, 32'h9999);

    // Sustained dual-issue with distinct addresses: pair i is presented at cycle i+2
    for (int i = 0; i < 20; i++) begin
      drive(1, 3'((2 * i) % 8), 16'h1000 + 16'(i), 1, 3'((2 * i + 1) % 8), 16'h2000 + 16'(i), 0, 0);
      #1;
      check($sformatf("s%0d_rdy", i), {30'd0, wb_bus.alu_ready, wb_bus.mem_ready}, 32'd3);
      if (i >= 2) begin
        check($sformatf("s%0d_we", i), {30'd0, wb_bus.write_en}, 32'd3);
        check($sformatf("s%0d_a0", i), {29'd0, wb_bus.reg_write_addr_0}, 32'((2 * (i - 2)) % 8));
        check($sformatf("s%0d_d0", i), {16'd0, wb_bus.data_in_0}, 32'h1000 + 32'(i - 2));
        check($sformatf("s%0d_a1", i), {29'd0, wb_bus.reg_write_addr_1}, 32'((2 * (i - 2) + 1) % 8));
        check($sformatf("s%0d_d1", i), {16'd0, wb_bus.data_in_1}, 32'h2000 + 32'(i - 2));
      end else begin
        check($sformatf("s%0d_we", i), {30'd0, wb_bus.write_en}, 32'd0);
      end
      @(negedge clk);
    end
    drive(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
    #1;
    check("drain0_d0", {16'd0, wb_bus.data_in_0}, 32'h1012);
    @(negedge clk);
    #1;
    check("drain1_d1", {16'd0, wb_bus.data_in_1}, 32'h2013);
    @(negedge clk);
    #1;
    check("drain2_idle", {31'd0, wb_bus.idle}, 32'd1);
    @(negedge clk);

    // Same-address pairs back to back leave 3 entries buffered, then reset discards them
    drive(1, 1, 16'hA001, 1, 1, 16'hA002, 1, 4);
    #1;
    check("fill0_rdy", {31'd0, wb_bus.alu_ready}, 32'd1);
    @(negedge clk);
    drive(1, 1, 16'hB001, 1, 1, 16'hB002, 1, 4);
    #1;
    check("fill1_rdy", {31'd0, wb_bus.mem_ready}, 32'd1);
    @(negedge clk);
    drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 4);
    #1;
    check("full3_rdy", {31'd0, wb_bus.alu_ready}, 32'd0);
    check("full3_we", {30'd0, wb_bus.write_en}, 32'd1);
    check("full3_d0", {16'd0, wb_bus.data_in_0}, 32'hA001);
    check("full3_pend0", {31'd0, wb_bus.pending_0}, 32'd1);
    rst = 1'b1;
    drive(1, 4, 16'h4444, 1, 4, 16'h4445, 1, 4);
    @(negedge clk);
    #1;
    check("rstmid_ready", {30'd0, wb_bus.alu_ready, wb_bus.mem_ready}, 32'd0);
    check("rstmid_we", {30'd0, wb_bus.write_en}, 32'd0);
    check("rstmid_addrs", {26'd0, wb_bus.reg_write_addr_0, wb_bus.reg_write_addr_1}, 32'd0);
    check("rstmid_d0", {16'd0, wb_bus.data_in_0}, 32'd0);
    check("rstmid_d1", {16'd0, wb_bus.data_in_1}, 32'd0);
    check("rstmid_idle", {31'd0, wb_bus.idle}, 32'd1);
    check("rstmid_pend", {30'd0, wb_bus.pending_0, wb_bus.pending_1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 16'h0, 0, 0, 16'h0, 1, 4);
    repeat (4) begin
      #1;
      check("post_rst_idle", {31'd0, wb_bus.idle}, 32'd1);
      @(negedge clk);
    end
    check("rf1_discard", {16'd0, rf[1]}, 32'hA001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_writeback_unit.md
Name: reg_writeback_unit

Overview:
- Producer side of the register file's dual write port.
- Collects results from two execution sources, ALU and memory, through valid/ready handshakes and holds them in a small in-order FIFO.
- Drains up to two results per cycle onto the register file's write_en / reg_write_addr_0/1 / data_in_0/1 inputs.
- Exposes pending-write lookups so decode can stall on read-after-write hazards.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 registers)
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high
- mem_valid  in  1  load result present
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load result
- mem_ready  out  1  load result accepted this cycle when mem_valid is also high
- write_en  out  2  to register file: 00 = none, 01 = port 0 only, 11 = both ports; 10 is never driven
- reg_write_addr_0  out  ADDR_W  port 0 address
- data_in_0  out  DATA_W  port 0 data
- reg_write_addr_1  out  ADDR_W  port 1 address
- data_in_1  out  DATA_W  port 1 data
- query_addr_0  in  ADDR_W  hazard lookup address 0
- query_addr_1  in  ADDR_W  hazard lookup address 1
- pending_0  out  1  a write to query_addr_0 is buffered or being presented
- pending_1  out  1  a write to query_addr_1 is buffered or being presented
- idle  out  1  FIFO empty and write_en == 00

Behaviour:
- Reset (synchronous, rst high at the edge):
  - FIFO count and pointers go to 0.
  - write_en = 00; all address and data outputs = 0.
  - alu_ready and mem_ready = 0 while rst is high.
  - Reset mid-operation discards all buffered and presented writes.
  - Reset takes priority over every other event in the same cycle.
- Acceptance (registered count):
  - alu_ready = mem_ready = (count <= DEPTH-2) and not rst.
  - Both producers can therefore always be accepted together.
  - A transfer occurs when valid and ready are both high at the edge.
- Enqueue order: if both are accepted in the same cycle, the ALU entry is written first and the memory entry second.
- Drain, at each edge, from the FIFO head as it stood before that edge:
  - 0 entries: write_en <= 00.
  - 1 entry: port 0 <= head; write_en <= 01.
  - >= 2 entries with different addresses: port 0 <= head, port 1 <= head+1; write_en <= 11.
  - >= 2 entries with the same address: only the head is issued (write_en <= 01). The second entry goes out the next cycle. This preserves program order.
- When write_en is 00 or 01, port 1 address and data hold their previous values.
- Simultaneous enqueue and dequeue in one cycle are both legal; count' = count + accepted - popped.
- Count never exceeds DEPTH. Pointers wrap modulo DEPTH.
- Latency: a result accepted at edge N is presented at the earliest at edge N+1 and committed by the register file at edge N+2.
- Throughput: 2 writes per cycle sustained, given distinct addresses.
- Hazard lookup (combinational):
  - pending_k is high when query_addr_k matches any valid FIFO entry.
  - pending_k is also high when it matches a presented port: port 0 when write_en[0], port 1 when write_en[1].
- idle is combinational from count and write_en.

Decomposition:
- Package reg_wb_pkg holds:
  - DATA_W, ADDR_W
  - WE_NONE = 2'b00, WE_P0 = 2'b01, WE_BOTH = 2'b11
  - the wb_entry_t struct {addr, data}
- One sub-module, reg_wb_fifo:
  - DEPTH-entry circular buffer, 2 pushes and 2 pops per cycle
  - exposes head and head+1 entries plus a per-entry valid vector for the hazard compare

Test Plan:
- Reset, then alu_valid with addr 2, data 1234 for one cycle:
  - alu_ready = 1 in that cycle.
  - Next cycle: write_en = 01, reg_write_addr_0 = 2, data_in_0 = 1234.
  - Following cycle: write_en = 00, idle = 1.
- Same cycle ALU {5, 5678} and mem {3, 1010}:
  - Next cycle: write_en = 11, port 0 = {5, 5678}, port 1 = {3, 1010}.
- Same cycle ALU {2, 2345} and mem {2, 9999}:
  - Cycle +1: write_en = 01, port 0 = {2, 2345}.
  - Cycle +2: write_en = 01, port 0 = {2, 9999}.
  - Register file reads 9999 from reg 2 afterwards.
- Hold both producers valid every cycle with distinct addresses:
  - count never exceeds 4; readies never drop.
  - write_en = 11 every cycle after the first.
- Buffer {6, 00AA} and query_addr_0 = 6, query_addr_1 = 1:
  - pending_0 = 1 from the accept edge through the presentation cycle, then 0.
  - pending_1 = 0 throughout.
- Fill the FIFO with 3 entries, then assert rst for one cycle:
  - Next cycle: write_en = 00, all outputs 0, idle = 1, pending_0/1 = 0.
  - The discarded data never reaches the register file.
